// File: rtl/char_glyph_loader.sv
// -----------------------------------------------------------------------------
// char_glyph_loader
//
// Purpose:
//   Feeds the VGA character display stage. Accepts three 8-bit character codes,
//   reads the 16 rows of each 8x16 glyph from an external synchronous font ROM,
//   assembles them into a 16x24 shadow bitmap and then copies the whole bitmap
//   to char_line0..char_linef in one clock edge. With SYNC_COMMIT=1 the copy is
//   deferred to the next vsync falling edge, so a frame never shows a
//   half-updated bitmap.
//
// Parameters:
//   ROM_LAT      font ROM read latency in clk cycles (1..3)
//   SYNC_COMMIT  1: commit on next vsync falling edge, 0: commit after fetch
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   char_valid/char_ready  request handshake (accept on valid & ready)
//   char_codes             {code0, code1, code2}, code0 is leftmost
//   rom_en, rom_addr       ROM read strobe and address {code, glyph_row}
//   rom_data               glyph row from ROM, ROM_LAT cycles after rom_en
//   vsync                  active-low vertical sync from the display stage
//   busy                   high from accept until the commit cycle ends
//   update_done            one-cycle pulse in the commit cycle
//   char_line0..f          displayed bitmap rows, bit23 = leftmost pixel
// -----------------------------------------------------------------------------
module char_glyph_loader #(
  parameter int unsigned ROM_LAT     = 1,
  parameter bit          SYNC_COMMIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic [23:0] char_codes,
  output logic        rom_en,
  output logic [11:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        vsync,
  output logic        busy,
  output logic        update_done,
  output logic [23:0] char_line0,
  output logic [23:0] char_line1,
  output logic [23:0] char_line2,
  output logic [23:0] char_line3,
  output logic [23:0] char_line4,
  output logic [23:0] char_line5,
  output logic [23:0] char_line6,
  output logic [23:0] char_line7,
  output logic [23:0] char_line8,
  output logic [23:0] char_line9,
  output logic [23:0] char_linea,
  output logic [23:0] char_lineb,
  output logic [23:0] char_linec,
  output logic [23:0] char_lined,
  output logic [23:0] char_linee,
  output logic [23:0] char_linef
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    WAIT_VS,
    COMMIT
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  logic [23:0] codes_reg;
  logic [3:0]  row_reg;
  logic [1:0]  chr_reg;
  logic [1:0]  drain_cnt_reg;
  logic        vsync_d_reg;

  // Capture delay line: stage k holds the issue made k+1 edges earlier.
  logic        cap_vld_reg [ROM_LAT];
  logic [3:0]  cap_row_reg [ROM_LAT];
  logic [1:0]  cap_chr_reg [ROM_LAT];

  logic        cap_en;
  logic [3:0]  cap_row;
  logic [1:0]  cap_chr;

  logic        accept;
  logic        issue_last;
  logic        drain_done;
  logic        vs_fall;
  logic        commit_fire;
  logic [7:0]  code_sel;
  logic [23:0] line_w [16];

  assign accept     = char_valid && (state_reg == IDLE);
  assign issue_last = (row_reg == 4'd15) && (chr_reg == 2'd2);
  // DRAIN covers ROM_LAT cycles up to the last capture plus one cycle so the
  // final shadow write has landed before the bitmap is copied out.
  assign drain_done = (drain_cnt_reg == 2'(ROM_LAT));
  assign vs_fall    = vsync_d_reg && !vsync;

  assign cap_en  = cap_vld_reg[ROM_LAT-1];
  assign cap_row = cap_row_reg[ROM_LAT-1];
  assign cap_chr = cap_chr_reg[ROM_LAT-1];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    commit_fire = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (issue_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done) begin
          if (SYNC_COMMIT) begin
            state_next = WAIT_VS;
          end else begin
            state_next  = COMMIT;
            commit_fire = 1'b1;
          end
        end
      end
      WAIT_VS: begin
        // Only falling edges seen while waiting count; earlier ones are lost.
        if (vs_fall) begin
          state_next  = COMMIT;
          commit_fire = 1'b1;
        end
      end
      COMMIT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign char_ready  = (state_reg == IDLE);
  assign busy        = (state_reg != IDLE);
  assign rom_en      = (state_reg == FETCH);
  assign update_done = (state_reg == COMMIT);

  // rom_addr follows the issue counters, so it holds its last value in DRAIN.
  always_comb begin
    unique case (chr_reg)
      2'd0:    code_sel = codes_reg[23:16];
      2'd1:    code_sel = codes_reg[15:8];
      default: code_sel = codes_reg[7:0];
    endcase
  end

  assign rom_addr = {code_sel, row_reg};

  // ---------------------------------------------------------------------------
  // Issue counters, drain counter, vsync sampler
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      codes_reg     <= '0;
      row_reg       <= '0;
      chr_reg       <= '0;
      drain_cnt_reg <= '0;
      vsync_d_reg   <= 1'b1;
    end else begin
      vsync_d_reg <= vsync;
      if (accept) begin
        codes_reg <= char_codes;
        row_reg   <= '0;
        chr_reg   <= '0;
      end else if ((state_reg == FETCH) && !issue_last) begin
        // Row-major walk: three characters per glyph row.
        if (chr_reg == 2'd2) begin
          chr_reg <= '0;
          row_reg <= row_reg + 4'd1;
        end else begin
          chr_reg <= chr_reg + 2'd1;
        end
      end
      if (state_reg == FETCH) begin
        drain_cnt_reg <= '0;
      end else if (state_reg == DRAIN) begin
        drain_cnt_reg <= drain_cnt_reg + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        cap_vld_reg[i] <= 1'b0;
        cap_row_reg[i] <= '0;
        cap_chr_reg[i] <= '0;
      end
    end else begin
      cap_vld_reg[0] <= rom_en;
      cap_row_reg[0] <= row_reg;
      cap_chr_reg[0] <= chr_reg;
      for (int i = 1; i < ROM_LAT; i++) begin
        cap_vld_reg[i] <= cap_vld_reg[i-1];
        cap_row_reg[i] <= cap_row_reg[i-1];
        cap_chr_reg[i] <= cap_chr_reg[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow bitmap and displayed bitmap, one row per generate slice
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 16; gi++) begin : g_row
    logic [23:0] shadow_reg;
    logic [23:0] line_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        shadow_reg <= '0;
        line_reg   <= '0;
      end else begin
        if (cap_en && (cap_row == 4'(gi))) begin
          unique case (cap_chr)
            2'd0:    shadow_reg[23:16] <= rom_data;
            2'd1:    shadow_reg[15:8]  <= rom_data;
            default: shadow_reg[7:0]   <= rom_data;
          endcase
        end
        if (commit_fire) begin
          line_reg <= shadow_reg;
        end
      end
    end

    assign line_w[gi] = line_reg;
  end

  assign char_line0 = line_w[0];
  assign char_line1 = line_w[1];
  assign char_line2 = line_w[2];
  assign char_line3 = line_w[3];
  assign char_line4 = line_w[4];
  assign char_line5 = line_w[5];
  assign char_line6 = line_w[6];
  assign char_line7 = line_w[7];
  assign char_line8 = line_w[8];
  assign char_line9 = line_w[9];
  assign char_linea = line_w[10];
  assign char_lineb = line_w[11];
  assign char_linec = line_w[12];
  assign char_lined = line_w[13];
  assign char_linee = line_w[14];
  assign char_linef = line_w[15];

endmodule
